chirp_framer: RTL and testbench

CHIRP_FRAMER -- requirements
Module: chirp_framer

---
 rtl/fmcw_pkg.sv | 12 +
 rtl/chirp_framer.sv | 153 +++++++++++++++
 tb/tb_chirp_framer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fmcw_pkg.sv
// rtl/fmcw_pkg.sv - shared FMCW front-end types: framer state encoding and default sample width
package fmcw_pkg;

    localparam int DEFAULT_DATA_WIDTH = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2
    } framer_state_t;

endpackage

// File: rtl/chirp_framer.sv
// rtl/chirp_framer.sv - aligns N-sample capture frames to chirp ramps after a settling skip
module chirp_framer
    import fmcw_pkg::*;
#(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SKIP       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic                         arm,
    input  logic                         ramp_start,
    input  logic signed [DATA_WIDTH-1:0] di,
    output logic                         en,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         frame_active,
    output logic [15:0]                  frame_ctr,
    output logic                         miss,
    output logic                         sat
);

    localparam int IW  = $clog2(N);
    localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKW-1:0] SKIP_LOAD = SKW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(N - 1);
    localparam logic signed [DATA_WIDTH-1:0] FS_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] FS_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    framer_state_t r_state;
    framer_state_t w_state_nxt;

    logic [SKW-1:0]                r_skip_cnt;
    logic [SKW-1:0]                w_skip_nxt;
    logic [IW-1:0]                 r_idx;
    logic [IW-1:0]                 w_idx_nxt;
    logic                          r_pending;
    logic                          r_en;
    logic signed [DATA_WIDTH-1:0]  r_dout;
    logic                          r_frame_active;
    logic [15:0]                   r_frame_ctr;
    logic                          r_miss;
    logic                          r_sat;

    logic w_pend;
    logic w_sample0;
    logic w_frame_done;
    logic w_drop;
    logic w_full_scale;

    assign w_pend       = r_pending | ramp_start;
    assign w_full_scale = (di == FS_POS) || (di == FS_NEG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // The capture index holds the index of the sample taken on the next
    // strobe; sample 0 is taken on the edge that enters CAPTURE.
    always_comb begin
        w_state_nxt  = r_state;
        w_skip_nxt   = r_skip_cnt;
        w_idx_nxt    = r_idx;
        w_sample0    = 1'b0;
        w_frame_done = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend) begin
                    if (!arm) begin
                        w_drop = 1'b1;
                    end else if (SKIP == 0) begin
                        w_state_nxt = ST_CAPTURE;
                        w_idx_nxt   = IW'(1);
                        w_sample0   = 1'b1;
                    end else begin
                        w_state_nxt = ST_SKIP;
                        w_skip_nxt  = SKIP_LOAD;
                    end
                end
            end
            ST_SKIP: begin
                w_drop = w_pend;
                if (r_skip_cnt == '0) begin
                    w_state_nxt = ST_CAPTURE;
                    w_idx_nxt   = IW'(1);
                    w_sample0   = 1'b1;
                end else begin
                    w_skip_nxt = r_skip_cnt - SKW'(1);
                end
            end
            ST_CAPTURE: begin
                w_drop = w_pend;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_frame_done = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt     <= '0;
            r_idx          <= '0;
            r_pending      <= 1'b0;
            r_en           <= 1'b0;
            r_dout         <= '0;
            r_frame_active <= 1'b0;
            r_frame_ctr    <= '0;
            r_miss         <= 1'b0;
            r_sat          <= 1'b0;
        end else if (clk_en) begin
            r_skip_cnt     <= w_skip_nxt;
            r_idx          <= w_idx_nxt;
            r_pending      <= 1'b0;
            r_en           <= w_sample0;
            r_dout         <= di;
            r_frame_active <= (w_state_nxt == ST_CAPTURE);
            if (w_frame_done) begin
                r_frame_ctr <= r_frame_ctr + 16'd1;
            end
            // A drop on an unarmed edge must still be reported.
            if (w_drop) begin
                r_miss <= 1'b1;
            end else if (!arm) begin
                r_miss <= 1'b0;
            end
            if (w_sample0) begin
                r_sat <= w_full_scale;
            end else if (r_state == ST_CAPTURE && w_full_scale) begin
                r_sat <= 1'b1;
            end
        end else if (ramp_start) begin
            r_pending <= 1'b1;
        end
    end

    assign en           = r_en;
    assign dout         = r_dout;
    assign frame_active = r_frame_active;
    assign frame_ctr    = r_frame_ctr;
    assign miss         = r_miss;
    assign sat          = r_sat;

endmodule

// File: tb/tb_chirp_framer.sv
// tb/tb_chirp_framer.sv - directed vector bench for chirp_framer with N=8, SKIP=2
module tb_chirp_framer;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        arm;
    logic        ramp_start;
    logic [13:0] di;
    logic        en;
    logic [13:0] dout;
    logic        frame_active;
    logic [15:0] frame_ctr;
    logic        miss;
    logic        sat;

    int n_cmp;
    int n_err;

    chirp_framer #(
        .N         (8),
        .DATA_WIDTH(14),
        .SKIP      (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .arm         (arm),
        .ramp_start  (ramp_start),
        .di          (di),
        .en          (en),
        .dout        (dout),
        .frame_active(frame_active),
        .frame_ctr   (frame_ctr),
        .miss        (miss),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic        ramp;
        logic [13:0] di;
        logic        en;
        logic [13:0] dout;
        logic        fa;
        logic [15:0] ctr;
        logic        miss;
        logic        sat;
    } vec_t;

    localparam int NV = 68;
    vec_t tv[NV];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input logic ce, input logic rs, input logic [13:0] d);
        clk_en     = ce;
        ramp_start = rs;
        di         = d;
        @(posedge clk);
        #1;
        clk_en     = 1'b0;
        ramp_start = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic e_en, input logic [13:0] e_dout,
                           input logic e_fa, input logic [15:0] e_ctr,
                           input logic e_miss, input logic e_sat);
        chk({tag, " en"},   {15'd0, en},           {15'd0, e_en});
        chk({tag, " dout"}, {2'd0, dout},          {2'd0, e_dout});
        chk({tag, " fa"},   {15'd0, frame_active}, {15'd0, e_fa});
        chk({tag, " ctr"},  frame_ctr,             e_ctr);
        chk({tag, " miss"}, {15'd0, miss},         {15'd0, e_miss});
        chk({tag, " sat"},  {15'd0, sat},          {15'd0, e_sat});
    endtask

    initial begin
        int ramps[7];
        int arm_lo[3];
        int sof[5];
        ramps  = '{5, 16, 21, 30, 36, 47, 58};
        arm_lo = '{27, 30, 35};
        sof    = '{7, 18, 38, 49, 60};

        n_cmp = 0;
        n_err = 0;

        // Vector k is applied on strobe edge k with di=k unless overridden.
        for (int k = 0; k < NV; k++) begin
            tv[k].arm  = 1'b1;
            tv[k].ramp = 1'b0;
            tv[k].di   = 14'(k);
            tv[k].en   = 1'b0;
            tv[k].dout = 14'(k);
            tv[k].fa   = 1'b0;
            tv[k].ctr  = (k < 14) ? 16'd0 : (k < 25) ? 16'd1 : (k < 45) ? 16'd2 :
                         (k < 56) ? 16'd3 : (k < 67) ? 16'd4 : 16'd5;
            tv[k].miss = ((k >= 21 && k <= 26) || (k >= 30 && k <= 34));
            tv[k].sat  = ((k >= 41 && k <= 48) || (k >= 60));
        end
        for (int i = 0; i < 7; i++) tv[ramps[i]].ramp = 1'b1;
        for (int i = 0; i < 3; i++) tv[arm_lo[i]].arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tv[sof[i]].en = 1'b1;
            for (int j = 0; j < 7; j++) tv[sof[i] + j].fa = 1'b1;
        end
        tv[41].di = 14'h1FFF; tv[41].dout = 14'h1FFF;
        tv[57].di = 14'h2000; tv[57].dout = 14'h2000;
        tv[60].di = 14'h2000; tv[60].dout = 14'h2000;

        rst_n      = 1'b1;
        clk_en     = 1'b0;
        arm        = 1'b0;
        ramp_start = 1'b0;
        di         = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_all("reset", 1'b0, 14'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            arm = tv[k].arm;
            tick(1'b1, tv[k].ramp, tv[k].di);
            chk_all($sformatf("v%0d", k), tv[k].en, tv[k].dout, tv[k].fa,
                    tv[k].ctr, tv[k].miss, tv[k].sat);
        end

        // Strobe every third clock; the ramp arrives between strobes.
        arm = 1'b1;
        tick(1'b0, 1'b1, 14'd100);
        chk_all("sparse hold0", 1'b0, 14'd67, 1'b0, 16'd5, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 14'd101);
        tick(1'b1, 1'b0, 14'd200);
        chk_all("sparse accept", 1'b0, 14'd200, 1'b0, 16'd5, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 14'd0);
        tick(1'b0, 1'b0, 14'd0);
        tick(1'b1, 1'b0, 14'd201);
        tick(1'b0, 1'b0, 14'd0);
        tick(1'b0, 1'b0, 14'd0);
        tick(1'b1, 1'b0, 14'd202);
        chk_all("sparse sof", 1'b1, 14'd202, 1'b1, 16'd5, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 14'd0);
        tick(1'b0, 1'b0, 14'd0);
        chk_all("sparse sof hold", 1'b1, 14'd202, 1'b1, 16'd5, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b0, 14'd0);
            tick(1'b0, 1'b0, 14'd0);
            tick(1'b1, 1'b0, 14'(202 + i));
        end
        chk_all("sparse end", 1'b0, 14'd209, 1'b0, 16'd6, 1'b0, 1'b0);

        // Reset at capture index 4 with sat and miss both set.
        tick(1'b1, 1'b1, 14'd0);
        tick(1'b1, 1'b0, 14'd1);
        tick(1'b1, 1'b0, 14'd2);
        tick(1'b1, 1'b0, 14'd3);
        tick(1'b1, 1'b0, 14'h1FFF);
        tick(1'b1, 1'b1, 14'd5);
        tick(1'b1, 1'b0, 14'd6);
        chk_all("pre reset", 1'b0, 14'd6, 1'b1, 16'd6, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async reset", 1'b0, 14'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1'b1, 1'b1, 14'd10);
        tick(1'b1, 1'b0, 14'd11);
        tick(1'b1, 1'b0, 14'd12);
        chk_all("post reset sof", 1'b1, 14'd12, 1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 1; i < 7; i++) tick(1'b1, 1'b0, 14'(12 + i));
        chk_all("post reset idx6", 1'b0, 14'd18, 1'b1, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 14'd19);
        chk_all("post reset end", 1'b0, 14'd19, 1'b0, 16'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
